// File: rtl/cmd_snd_pkg.sv
// rtl/cmd_snd_pkg.sv - shared types and constants for the 24-bit command sender
// Optional feature macro: CMD_SND_CHKSUM_EN (adds the CHK state and checksum helper).
package cmd_snd_pkg;

    localparam int FRAME_BITS   = 10;    // start + 8 data + stop
    localparam int BAUD_DIV_DEF = 2604;  // 50 MHz / 19200 baud

`ifdef CMD_SND_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, HIGH, MID, LOW, CHK} state_t;

    // Inverted modulo-256 sum of the three command bytes.
    function automatic logic [7:0] chk8(input logic [23:0] w);
        logic [7:0] s;
        s = w[23:16] + w[15:8] + w[7:0];
        return ~s;
    endfunction
`else
    typedef enum logic [1:0] {IDLE, HIGH, MID, LOW} state_t;
`endif

endpackage

// File: rtl/cmd_snd_if.sv
// rtl/cmd_snd_if.sv - host/serial-side signal bundle of the command sender
// Signals: snd_cmd (send request), cmd[23:0] (word), TX (serial line, idle high),
//          tx_busy (word in flight), resp_sent (one-cycle done pulse).
// Modports: master = host side, slave = cmd_snd.
interface cmd_snd_if;
    logic        snd_cmd;
    logic [23:0] cmd;
    logic        TX;
    logic        tx_busy;
    logic        resp_sent;

    modport master (output snd_cmd, output cmd,
                    input  TX, input tx_busy, input resp_sent);
    modport slave  (input  snd_cmd, input cmd,
                    output TX, output tx_busy, output resp_sent);
endinterface

// File: rtl/cmd_snd_uart_tx8.sv
// rtl/cmd_snd_uart_tx8.sv - 8N1 byte serializer with baud and bit counters
// Ports: clk, rst_n (async active-low), trmt (load and start a byte), tx_data[7:0],
//        TX (registered serial out, idle high), tx_done (high in the last cycle of the stop bit).
module uart_tx8
    import cmd_snd_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          w_wrap;
    logic [3:0]    w_bit_nxt;

    assign w_wrap    = r_busy && (r_baud == BW'(BAUD_DIV - 1));
    assign w_bit_nxt = r_bit + 4'd1;
    // Byte done when the wrap would take the bit count to 10; a trmt in the
    // same cycle starts the next start bit with no idle gap.
    assign tx_done   = w_wrap && (w_bit_nxt == 4'(FRAME_BITS));
    assign TX        = r_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_busy  <= 1'b0;
        end else if (trmt) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= {tx_data, 1'b0};
            r_busy  <= 1'b1;
        end else if (w_wrap) begin
            r_baud  <= '0;
            // Shifting in ones produces the stop bit and then the idle level.
            r_shift <= {1'b1, r_shift[8:1]};
            if (tx_done) begin
                r_bit  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_bit  <= w_bit_nxt;
            end
        end else if (r_busy) begin
            r_baud <= r_baud + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_snd.sv
// rtl/cmd_snd.sv - sends a 24-bit word as three back-to-back UART bytes, high byte first
// Ports: clk, rst_n (async active-low), bus (cmd_snd_if.slave: snd_cmd, cmd, TX, tx_busy, resp_sent).
// Optional feature macro: CMD_SND_CHKSUM_EN appends an inverted-sum checksum byte.
module cmd_snd
    import cmd_snd_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    cmd_snd_if.slave   bus
);

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_cmd;
    logic        r_resp;
    logic        w_trmt;
    logic [7:0]  w_tx_data;
    logic        w_resp_set;
    logic        w_done;

    uart_tx8 #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (w_trmt),
        .tx_data (w_tx_data),
        .TX      (bus.TX),
        .tx_done (w_done)
    );

    assign bus.tx_busy   = (r_state != IDLE);
    assign bus.resp_sent = r_resp;

    always_comb begin
        w_next     = r_state;
        w_trmt     = 1'b0;
        w_tx_data  = 8'h00;
        w_resp_set = 1'b0;
        case (r_state)
            IDLE: begin
                // The first byte comes straight from the input so the start
                // bit is driven on the accept edge itself.
                if (bus.snd_cmd) begin
                    w_trmt    = 1'b1;
                    w_tx_data = bus.cmd[23:16];
                    w_next    = HIGH;
                end
            end
            HIGH: begin
                if (w_done) begin
                    w_trmt    = 1'b1;
                    w_tx_data = r_cmd[15:8];
                    w_next    = MID;
                end
            end
            MID: begin
                if (w_done) begin
                    w_trmt    = 1'b1;
                    w_tx_data = r_cmd[7:0];
                    w_next    = LOW;
                end
            end
            LOW: begin
                if (w_done) begin
`ifdef CMD_SND_CHKSUM_EN
                    w_trmt    = 1'b1;
                    w_tx_data = chk8(r_cmd);
                    w_next    = CHK;
`else
                    w_resp_set = 1'b1;
                    w_next     = IDLE;
`endif
                end
            end
`ifdef CMD_SND_CHKSUM_EN
            CHK: begin
                if (w_done) begin
                    w_resp_set = 1'b1;
                    w_next     = IDLE;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_resp  <= w_resp_set;
            if (r_state == IDLE && bus.snd_cmd) begin
                r_cmd <= bus.cmd;
            end
        end
    end

endmodule

// File: tb/tb_cmd_snd.sv
// tb/tb_cmd_snd.sv - self-checking bench for cmd_snd with a UART line decoder as reference
module tb_cmd_snd;

    localparam int B = 4;
`ifdef CMD_SND_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int WORD = NB * 10 * B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_snd_if u_if();

    cmd_snd #(.BAUD_DIV(B)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.resp_sent === 1'b1) resp_cnt <= resp_cnt + 1;
        if (u_if.tx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    // Line decoder: finds a falling edge, samples each bit at its centre,
    // keeps only frames completed without reset and with a valid stop bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && u_if.TX === 1'b0) begin
                logic [7:0] d;
                logic       ok;
                int         st;
                st = cyc;
                ok = 1'b1;
                d  = 8'h00;
                repeat (B / 2) @(negedge clk);
                ok = ok & rst_n & (u_if.TX === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    d[i] = u_if.TX;
                    ok = ok & rst_n;
                end
                repeat (B) @(negedge clk);
                ok = ok & rst_n & (u_if.TX === 1'b1);
                if (ok) begin
                    got_q.push_back(d);
                    start_q.push_back(st);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected byte stream for one word.
    task automatic expect_word(input logic [23:0] w);
        int s;
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`ifdef CMD_SND_CHKSUM_EN
        s = (int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0])) % 256;
        exp_q.push_back(8'(255 - s));
`else
        s = 0;
`endif
    endtask

    task automatic send(input logic [23:0] w, output int acc);
        expect_word(w);
        u_if.cmd     = w;
        u_if.snd_cmd = 1'b1;
        @(negedge clk);
        u_if.snd_cmd = 1'b0;
        u_if.cmd     = 24'($urandom);
        acc = cyc;
    endtask

    task automatic wait_resp(output int rc);
        int n;
        n  = 0;
        rc = -1;
        while (u_if.resp_sent !== 1'b1 && n < 2 * WORD + 20) begin
            @(negedge clk);
            n++;
        end
        if (u_if.resp_sent === 1'b1) rc = cyc;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (u_if.TX !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", u_if.TX); end
        tests++; if (u_if.tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", u_if.tx_busy); end
        tests++; if (u_if.resp_sent !== 1'b0) begin fails++; $display("FAIL reset_resp got %b want 0", u_if.resp_sent); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (u_if.TX !== 1'b1 || u_if.tx_busy !== 1'b0) begin
            fails++; $display("FAIL post_reset tx=%b busy=%b want 1/0", u_if.TX, u_if.tx_busy);
        end
    endtask

    task automatic test_basic;
        int acc, rc, gb, eb, rb, bb, sb;
        gb = got_q.size(); eb = exp_q.size(); sb = start_q.size();
        rb = resp_cnt; bb = busy_cnt;
        send(24'hA53C0F, acc);
        tests++; if (u_if.TX !== 1'b0) begin fails++; $display("FAIL basic_accept_tx got %b want 0", u_if.TX); end
        tests++; if (u_if.tx_busy !== 1'b1) begin fails++; $display("FAIL basic_accept_busy got %b want 1", u_if.tx_busy); end
        wait_resp(rc);
        tests++; if (rc - acc != WORD) begin fails++; $display("FAIL basic_latency got %0d want %0d", rc - acc, WORD); end
        @(negedge clk);
        tests++; if (u_if.resp_sent !== 1'b0) begin fails++; $display("FAIL basic_resp_width got %b want 0", u_if.resp_sent); end
        tests++; if (busy_cnt - bb != WORD) begin fails++; $display("FAIL basic_busy_len got %0d want %0d", busy_cnt - bb, WORD); end
        tests++; if (resp_cnt - rb != 1) begin fails++; $display("FAIL basic_resp_cnt got %0d want 1", resp_cnt - rb); end
        tests++; if (got_q.size() - gb != NB) begin fails++; $display("FAIL basic_nbytes got %0d want %0d", got_q.size() - gb, NB); end
        for (int i = 0; i < NB && gb + i < got_q.size(); i++) begin
            tests++; if (got_q[gb + i] !== exp_q[eb + i]) begin
                fails++; $display("FAIL basic_byte%0d got %h want %h", i, got_q[gb + i], exp_q[eb + i]);
            end
        end
        for (int i = 0; i < NB && sb + i < start_q.size(); i++) begin
            tests++; if (start_q[sb + i] != acc + i * 10 * B) begin
                fails++; $display("FAIL basic_start%0d got %0d want %0d", i, start_q[sb + i], acc + i * 10 * B);
            end
        end
`ifdef CMD_SND_CHKSUM_EN
        tests++; if (got_q.size() > gb + 3 && got_q[gb + 3] !== 8'h0F) begin
            fails++; $display("FAIL basic_chk got %h want 0f", got_q[gb + 3]);
        end
`endif
    endtask

    task automatic test_busy_protect;
        int acc, rc, gb, eb, rb;
        gb = got_q.size(); eb = exp_q.size(); rb = resp_cnt;
        send(24'hA53C0F, acc);
        repeat (10 * B + 15) @(negedge clk);
        u_if.cmd = 24'h123456;
        u_if.snd_cmd = 1'b1;
        @(negedge clk);
        u_if.snd_cmd = 1'b0;
        wait_resp(rc);
        tests++; if (rc - acc != WORD) begin fails++; $display("FAIL busy_latency got %0d want %0d", rc - acc, WORD); end
        repeat (20) @(negedge clk);
        tests++; if (resp_cnt - rb != 1) begin fails++; $display("FAIL busy_resp_cnt got %0d want 1", resp_cnt - rb); end
        tests++; if (got_q.size() - gb != NB) begin fails++; $display("FAIL busy_nbytes got %0d want %0d", got_q.size() - gb, NB); end
        for (int i = 0; i < NB && gb + i < got_q.size(); i++) begin
            tests++; if (got_q[gb + i] !== exp_q[eb + i]) begin
                fails++; $display("FAIL busy_byte%0d got %h want %h", i, got_q[gb + i], exp_q[eb + i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc, rc, gb, eb, rb, nw;
        logic [23:0] w;
        gb = got_q.size(); eb = exp_q.size(); rb = resp_cnt;
        send(24'($urandom), acc);
        wait_resp(rc);
        nw = 1;
        for (int k = 0; k < 5; k++) begin
            w = (k == 0) ? 24'h00FF80 : 24'($urandom);
            send(w, acc);
            nw++;
            tests++; if (acc != rc + 1) begin fails++; $display("FAIL b2b_accept%0d got %0d want %0d", k, acc, rc + 1); end
            tests++; if (u_if.TX !== 1'b0) begin fails++; $display("FAIL b2b_start%0d got %b want 0", k, u_if.TX); end
            wait_resp(rc);
            tests++; if (rc - acc != WORD) begin fails++; $display("FAIL b2b_latency%0d got %0d want %0d", k, rc - acc, WORD); end
        end
        @(negedge clk);
        tests++; if (resp_cnt - rb != nw) begin fails++; $display("FAIL b2b_resp_cnt got %0d want %0d", resp_cnt - rb, nw); end
        tests++; if (got_q.size() - gb != NB * nw) begin fails++; $display("FAIL b2b_nbytes got %0d want %0d", got_q.size() - gb, NB * nw); end
        for (int i = 0; i < NB * nw && gb + i < got_q.size(); i++) begin
            tests++; if (got_q[gb + i] !== exp_q[eb + i]) begin
                fails++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[gb + i], exp_q[eb + i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc, rc, gb, eb, rb;
        gb = got_q.size(); rb = resp_cnt;
        send(24'hA53C0F, acc);
        // Frame bit 5 of the second byte is its 5th data bit.
        repeat (10 * B + 5 * B + 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (u_if.TX !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", u_if.TX); end
        tests++; if (u_if.tx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", u_if.tx_busy); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        tests++; if (resp_cnt != rb) begin fails++; $display("FAIL rstmid_resp got %0d want 0", resp_cnt - rb); end
        tests++; if (got_q.size() - gb != 1) begin fails++; $display("FAIL rstmid_partial got %0d bytes want 1", got_q.size() - gb); end
        tests++; if (got_q.size() > gb && got_q[gb] !== 8'hA5) begin fails++; $display("FAIL rstmid_first got %h want a5", got_q[gb]); end
        gb = got_q.size(); eb = exp_q.size(); rb = resp_cnt;
        send(24'h010203, acc);
        wait_resp(rc);
        tests++; if (rc - acc != WORD) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", rc - acc, WORD); end
        @(negedge clk);
        tests++; if (got_q.size() - gb != NB) begin fails++; $display("FAIL rstmid_nbytes got %0d want %0d", got_q.size() - gb, NB); end
        for (int i = 0; i < NB && gb + i < got_q.size(); i++) begin
            tests++; if (got_q[gb + i] !== exp_q[eb + i]) begin
                fails++; $display("FAIL rstmid_byte%0d got %h want %h", i, got_q[gb + i], exp_q[eb + i]);
            end
        end
    endtask

    task automatic test_idle;
        int bad_tx, bad_busy, bad_resp;
        bad_tx = 0; bad_busy = 0; bad_resp = 0;
        repeat (1000) begin
            @(negedge clk);
            if (u_if.TX !== 1'b1) bad_tx++;
            if (u_if.tx_busy !== 1'b0) bad_busy++;
            if (u_if.resp_sent !== 1'b0) bad_resp++;
        end
        tests++; if (bad_tx != 0) begin fails++; $display("FAIL idle_tx low cycles %0d want 0", bad_tx); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL idle_busy high cycles %0d want 0", bad_busy); end
        tests++; if (bad_resp != 0) begin fails++; $display("FAIL idle_resp high cycles %0d want 0", bad_resp); end
    endtask

    initial begin
        u_if.snd_cmd = 1'b0;
        u_if.cmd     = 24'h0;
        rst_n        = 1'b0;
        test_reset;
        test_idle;
        test_basic;
        test_busy_protect;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
